// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding,
// byte-enable constants and the read-modify-write byte merge.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Per byte lane: take the new write data where enabled, otherwise keep the
  // word currently stored in the RAM. be[i] covers data[8*i+7:8*i].
  function automatic logic [31:0] merge_be(input logic [3:0]  be,
                                           input logic [31:0] wdata,
                                           input logic [31:0] rdata);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first valid requester at or
// after the pointer (wrapping), as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (!found_s && valid_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between NREQ
// requesters. Reads and full-word writes take one RAM cycle; partial
// byte-enable writes use a read cycle followed by a merged write cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [4*NREQ-1:0]    req_be_i,
  input  logic [XLEN*NREQ-1:0] req_addr_i,
  input  logic [XLEN*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [XLEN-1:0]      rsp_rdata_o,
  output logic                 ram_ce_o,
  output logic                 ram_we_o,
  output logic [XLEN-1:0]      ram_addr_o,
  output logic [XLEN-1:0]      ram_wdata_o,
  input  logic [XLEN-1:0]      ram_rdata_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  logic [XLEN-1:0]  wr_addr_q, wr_addr_d;
  logic [NREQ-1:0]  wr_gnt_q, wr_gnt_d;

  logic [NREQ-1:0]  gnt_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  logic             sel_we_s;
  logic [3:0]       sel_be_s;
  logic [XLEN-1:0]  sel_addr_s;
  logic [XLEN-1:0]  sel_wdata_s;
  logic [XLEN-1:0]  sel_addr_al_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_s),
    .idx_o   (idx_s),
    .any_o   (any_s)
  );

  // Route the granted requester's fields; the RAM ignores the byte offset.
  always_comb begin
    sel_we_s      = req_we_i[idx_s];
    sel_be_s      = req_be_i[int'(idx_s)*4 +: 4];
    sel_addr_s    = req_addr_i[int'(idx_s)*XLEN +: XLEN];
    sel_wdata_s   = req_wdata_i[int'(idx_s)*XLEN +: XLEN];
    sel_addr_al_s = {sel_addr_s[XLEN-1:2], 2'b00};
  end

  // Next-state and RAM pin control; grants are only made in IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    wr_gnt_d    = wr_gnt_q;
    req_ready_o = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          req_ready_o = gnt_s;
          rsp_valid_d = gnt_s;
          ptr_d       = (int'(idx_s) == NREQ - 1) ? '0 : idx_s + IDX_W'(1);
          if (!sel_we_s) begin
            ram_ce_o    = 1'b1;
            ram_addr_o  = sel_addr_al_s;
            rsp_rdata_d = ram_rdata_i;
          end else if (sel_be_s == BE_FULL) begin
            ram_ce_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = sel_addr_al_s;
            ram_wdata_o = sel_wdata_s;
          end else if (sel_be_s == BE_NONE) begin
            // Nothing to write: accept and respond without touching the RAM.
            ram_ce_o = 1'b0;
          end else begin
            // Read cycle of the read-modify-write; response waits for WR.
            ram_ce_o    = 1'b1;
            ram_addr_o  = sel_addr_al_s;
            wr_data_d   = merge_be(sel_be_s, sel_wdata_s, ram_rdata_i);
            wr_addr_d   = sel_addr_al_s;
            wr_gnt_d    = gnt_s;
            rsp_valid_d = '0;
            state_d     = WR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        ram_ce_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = wr_addr_q;
        ram_wdata_o = wr_data_q;
        rsp_valid_d = wr_gnt_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, registered response and pending merged write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_gnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_gnt_q    <= wr_gnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a random
// phase, checked every cycle against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ-1:0]      req_we_i;
  logic [4*NREQ-1:0]    req_be_i;
  logic [XLEN*NREQ-1:0] req_addr_i;
  logic [XLEN*NREQ-1:0] req_wdata_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [XLEN-1:0]      rsp_rdata_o;
  logic                 ram_ce_o;
  logic                 ram_we_o;
  logic [XLEN-1:0]      ram_addr_o;
  logic [XLEN-1:0]      ram_wdata_o;
  logic [XLEN-1:0]      ram_rdata_i;

  // requester-side stimulus
  logic [NREQ-1:0] vld;
  logic            rw   [NREQ];
  logic [3:0]      be   [NREQ];
  logic [31:0]     ad   [NREQ];
  logic [31:0]     wd   [NREQ];

  // RAM behaviour (64 words) and reference memory image
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  typedef struct {
    int          g;
    logic [31:0] rd;
    int          due;
  } rsp_t;
  rsp_t rq[$];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          free_at  = 0;
  int          m_ptr    = 0;
  logic        pend_v   = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_a   = 32'h0;
  logic [31:0] pend_d   = 32'h0;

  // observations from the most recent cycle()
  logic [NREQ-1:0] obs_rdy, obs_rv;
  logic [31:0]     obs_rd, obs_addr, obs_wd;
  logic            obs_ce, obs_we;
  logic [NREQ-1:0] gseq [4];

  ram_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  assign ram_rdata_i = mem[ram_addr_o[7:2]];

  // Pack per-requester stimulus onto the flat DUT ports.
  always_comb begin
    req_valid_i = vld;
    req_we_i    = '0;
    req_be_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_we_i[i]            = rw[i];
      req_be_i[4*i +: 4]     = be[i];
      req_addr_i[32*i +: 32] = ad[i];
      req_wdata_i[32*i +: 32] = wd[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed big-endian write: byte at offset b lives in data[31-8b -: 8]
  // and is enabled by be[3-b].
  function automatic logic [31:0] bytewrite(input logic [31:0] old, input logic [3:0] bmask,
                                            input logic [31:0] nw);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (bmask[3-b]) r[31-8*b -: 8] = nw[31-8*b -: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    free_at = 0;
    pend_v  = 1'b0;
    rq.delete();
  endtask

  // One clock: check DUT outputs mid-cycle against the model, then let the
  // RAM take any write at the rising edge.
  task automatic cycle();
    int              g;
    int              c;
    logic [NREQ-1:0] e_rdy, e_rv;
    logic            e_ce, e_we;
    logic [31:0]     e_addr, e_wd, e_rd, a;
    @(negedge clk_i);
    cyc++;
    g = -1;
    if (cyc >= free_at) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (g < 0 && vld[c]) g = c;
      end
    end
    e_rdy = '0; e_ce = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
    if (g >= 0) begin
      e_rdy[g] = 1'b1;
      a        = {ad[g][31:2], 2'b00};
      free_at  = cyc + 1;
      m_ptr    = (g + 1) % NREQ;
      if (!rw[g]) begin
        e_ce = 1'b1; e_addr = a;
        rq.push_back('{g, ref_mem[a[7:2]], cyc + 1});
      end else if (be[g] == 4'hF) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = a; e_wd = wd[g];
        ref_mem[a[7:2]] = wd[g];
        rq.push_back('{g, 32'h0, cyc + 1});
      end else if (be[g] == 4'h0) begin
        rq.push_back('{g, 32'h0, cyc + 1});
      end else begin
        e_ce = 1'b1; e_addr = a;
        pend_v = 1'b1; pend_cyc = cyc + 1; pend_a = a;
        pend_d = bytewrite(ref_mem[a[7:2]], be[g], wd[g]);
        rq.push_back('{g, 32'h0, cyc + 2});
        free_at = cyc + 2;
      end
    end else if (pend_v && pend_cyc == cyc) begin
      e_ce = 1'b1; e_we = 1'b1; e_addr = pend_a; e_wd = pend_d;
      ref_mem[pend_a[7:2]] = pend_d;
      pend_v = 1'b0;
    end
    e_rv = '0; e_rd = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv[rq[0].g] = 1'b1;
      e_rd = rq[0].rd;
      void'(rq.pop_front());
    end
    chk("ready", 32'(req_ready_o), 32'(e_rdy));
    chk("ram_ce", 32'(ram_ce_o), 32'(e_ce));
    chk("ram_we", 32'(ram_we_o), 32'(e_we));
    chk("ram_addr", ram_addr_o, e_addr);
    chk("ram_wdata", ram_wdata_o, e_wd);
    chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
    if (e_rv != '0) chk("rsp_rdata", rsp_rdata_o, e_rd);
    obs_rdy = req_ready_o; obs_rv = rsp_valid_o; obs_rd = rsp_rdata_o;
    obs_ce = ram_ce_o; obs_we = ram_we_o; obs_addr = ram_addr_o; obs_wd = ram_wdata_o;
    @(posedge clk_i);
    if (obs_ce && obs_we) mem[obs_addr[7:2]] = obs_wd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic issue(input int r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    vld[r] = 1'b1; rw[r] = w; be[r] = b; ad[r] = a; wd[r] = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_rdy[r] && n < 20);
    if (!obs_rdy[r]) chk("grant_timeout", 32'(obs_rdy[r]), 32'h1);
    vld[r] = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    vld    = '0;
    for (int i = 0; i < NREQ; i++) begin
      rw[i] = 1'b0; be[i] = 4'h0; ad[i] = 32'h0; wd[i] = 32'h0;
    end
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_ce", 32'(ram_ce_o), 32'h0);
    model_reset();
    rst_ni = 1'b1;
    idle(2);

    // full write then read
    issue(0, 1'b1, 4'hF, 32'h08, 32'hDEADBEEF);
    chk("fw_we", 32'(obs_we), 32'h1);
    cycle();
    chk("fw_rsp", 32'(obs_rv), 32'h1);
    chk("fw_mem", mem[2], 32'hDEADBEEF);
    issue(0, 1'b0, 4'hF, 32'h08, 32'h0);
    cycle();
    chk("rd_rsp", 32'(obs_rv), 32'h1);
    chk("rd_data", obs_rd, 32'hDEADBEEF);

    // partial write: read cycle, merged write cycle, response after two
    issue(0, 1'b1, 4'b0100, 32'h08, 32'h00AA0000);
    chk("pw_a_we", 32'(obs_we), 32'h0);
    cycle();
    chk("pw_b_we", 32'(obs_we), 32'h1);
    chk("pw_b_wd", obs_wd, 32'hDEAABEEF);
    chk("pw_b_norsp", 32'(obs_rv), 32'h0);
    cycle();
    chk("pw_rsp", 32'(obs_rv), 32'h1);
    issue(0, 1'b0, 4'hF, 32'h08, 32'h0);
    cycle();
    chk("pw_rd", obs_rd, 32'hDEAABEEF);

    // misaligned read and no-op write
    issue(0, 1'b0, 4'hF, 32'h0B, 32'h0);
    chk("al_addr", obs_addr, 32'h08);
    cycle();
    chk("al_rd", obs_rd, 32'hDEAABEEF);
    issue(0, 1'b1, 4'h0, 32'h08, 32'hFFFFFFFF);
    chk("z_ce", 32'(obs_ce), 32'h0);
    cycle();
    chk("z_rsp", 32'(obs_rv), 32'h1);
    chk("z_mem", mem[2], 32'hDEAABEEF);

    // round-robin from reset with both requesters reading continuously
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1'b1;
    rw[0] = 1'b0; ad[0] = 32'h08;
    rw[1] = 1'b0; ad[1] = 32'h0C;
    vld = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      gseq[i] = obs_rdy;
    end
    chk("rr_g0", 32'(gseq[0]), 32'h1);
    chk("rr_g1", 32'(gseq[1]), 32'h2);
    chk("rr_g2", 32'(gseq[2]), 32'h1);
    chk("rr_g3", 32'(gseq[3]), 32'h2);
    vld = 2'b00;
    idle(2);

    // r1 partial write blocks r0 during the WR cycle
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0);
    rw[1] = 1'b1; be[1] = 4'b0011; ad[1] = 32'h10; wd[1] = 32'h12345678;
    rw[0] = 1'b0; ad[0] = 32'h14;
    vld = 2'b11;
    cycle();
    chk("blk_g1", 32'(obs_rdy), 32'h2);
    vld[1] = 1'b0;
    cycle();
    chk("blk_wr", 32'(obs_rdy), 32'h0);
    chk("blk_wr_we", 32'(obs_we), 32'h1);
    cycle();
    chk("blk_g0", 32'(obs_rdy), 32'h1);
    vld = 2'b00;
    idle(2);
    chk("blk_mem", mem[4], 32'h00005678);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!vld[r] && $urandom_range(0, 2) != 0) begin
          vld[r] = 1'b1;
          rw[r]  = 1'($urandom_range(0, 1));
          be[r]  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
          ad[r]  = {8'($urandom), 16'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
          wd[r]  = $urandom;
        end
      end
      cycle();
      for (int r = 0; r < NREQ; r++) begin
        if (obs_rdy[r]) vld[r] = 1'b0;
      end
    end
    vld = '0;
    idle(3);

    // reset during WR abandons the write and clears the pointer
    mem[8] = 32'hCAFEF00D; ref_mem[8] = 32'hCAFEF00D;
    issue(0, 1'b1, 4'b1000, 32'h20, 32'h11000000);
    rst_ni = 1'b0;
    #1;
    chk("mr_we", 32'(ram_we_o), 32'h0);
    chk("mr_ce", 32'(ram_ce_o), 32'h0);
    chk("mr_rsp", 32'(rsp_valid_o), 32'h0);
    chk("mr_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1'b1;
    chk("mr_mem", mem[8], 32'hCAFEF00D);
    rw[0] = 1'b0; ad[0] = 32'h20;
    rw[1] = 1'b0; ad[1] = 32'h24;
    vld = 2'b11;
    cycle();
    chk("mr_ptr", 32'(obs_rdy), 32'h1);
    vld[0] = 1'b0;
    cycle();
    vld = 2'b00;
    idle(3);
    chk("mr_mem2", mem[8], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
